// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request/response bundle between core and data memory
//
// Purpose: groups the core-to-memory request channel and the memory-to-core
// response channel so both ends share one declaration.
//
// Signals:
//   req_valid  core presents a request
//   req_ready  responder can accept a request
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_funct3 RISC-V funct3 (b/h/w/bu/hu)
//   req_wdata  store data, right-aligned
//   rsp_valid  response available
//   rsp_ready  core accepts the response
//   rsp_rdata  extended load result; 0 for stores and errors
//   rsp_err    access rejected
//
// Modports: master = core side, slave = responder side.

interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_addr,
        output req_funct3,
        output req_wdata,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_addr,
        input  req_funct3,
        input  req_wdata,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with programmable wait states
//
// Purpose: slave end of the core's load/store handshake. Accepts one request
// at a time, waits WAIT cycles, then commits the access (RV32I byte/half/word
// stores with byte enables, loads with sign/zero extension) and holds the
// response until the core takes it. Misaligned, illegal-funct3 and
// out-of-range accesses are reported on rsp_err and never touch memory.
//
// Parameters:
//   ADDR_W  word-address bits; memory is 2^ADDR_W 32-bit words
//   WAIT    wait states between acceptance and response (0..15)
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  dmem_responder_if.slave (request/response handshake)

module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;

    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [0:(1 << ADDR_W) - 1];

    logic        w_accept;
    logic        w_commit;

    logic        w_op_we;
    logic [31:0] w_op_addr;
    logic [2:0]  w_op_funct3;
    logic [31:0] w_op_wdata;

    logic        w_misaligned;
    logic        w_illegal;
    logic        w_out_of_range;
    logic        w_err;

    logic [1:0]        w_lane;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_word;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [31:0]       w_wrep;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_next = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The access is performed on the edge that enters RESP, exactly once.
    assign w_commit = (w_next == S_RESP) && (r_state != S_RESP) && !rst;

    // With WAIT=0 the commit edge is also the acceptance edge, so the request
    // latches are not yet loaded; take the operation straight from the bus.
    assign w_op_we     = (r_state == S_IDLE) ? bus.req_we     : r_we;
    assign w_op_addr   = (r_state == S_IDLE) ? bus.req_addr   : r_addr;
    assign w_op_funct3 = (r_state == S_IDLE) ? bus.req_funct3 : r_funct3;
    assign w_op_wdata  = (r_state == S_IDLE) ? bus.req_wdata  : r_wdata;

    // Error classification
    always_comb begin
        w_misaligned = 1'b0;
        w_illegal    = 1'b0;
        case (w_op_funct3)
            3'b001, 3'b101: w_misaligned = w_op_addr[0];
            3'b010:         w_misaligned = (w_op_addr[1:0] != 2'b00);
            default:        w_misaligned = 1'b0;
        endcase
        case (w_op_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            3'b100, 3'b101:         w_illegal = w_op_we;
            default:                w_illegal = 1'b0;
        endcase
    end

    assign w_out_of_range = |w_op_addr[31:ADDR_W+2];
    assign w_err          = w_misaligned || w_illegal || w_out_of_range;

    assign w_lane = w_op_addr[1:0];
    assign w_idx  = w_op_addr[ADDR_W+1:2];
    assign w_word = r_mem[w_idx];

    // Store byte enables; data is replicated across lanes so the enables
    // alone pick the destination bytes.
    always_comb begin
        w_be   = 4'b0000;
        w_wrep = w_op_wdata;
        case (w_op_funct3[1:0])
            2'b00: begin
                w_be   = 4'b0001 << w_lane;
                w_wrep = {4{w_op_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = 4'b0011 << w_lane;
                w_wrep = {2{w_op_wdata[15:0]}};
            end
            2'b10: begin
                w_be   = 4'b1111;
                w_wrep = w_op_wdata;
            end
            default: begin
                w_be   = 4'b0000;
                w_wrep = w_op_wdata;
            end
        endcase
    end

    // Load formatting
    assign w_shifted = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_load = 32'h0;
        case (w_op_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = w_shifted;
            3'b100:  w_load = {24'h0, w_shifted[7:0]};
            3'b101:  w_load = {16'h0, w_shifted[15:0]};
            default: w_load = 32'h0;
        endcase
    end

    // State, counter, request latches and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_funct3 <= 3'b000;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_addr   <= bus.req_addr;
                r_funct3 <= bus.req_funct3;
                r_wdata  <= bus.req_wdata;
                r_cnt    <= WAIT_CNT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_op_we || w_err) ? 32'h0 : w_load;
            end
        end
    end

    // Memory array; w_commit already excludes the reset edge, so a store
    // pending when reset arrives is never written.
    always_ff @(posedge clk) begin
        if (w_commit && w_op_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder (WAIT=2 and WAIT=0 instances)

module tb_dmem_responder;

    logic clk;
    logic rst;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.ADDR_W(10), .WAIT(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    dmem_responder #(.ADDR_W(10), .WAIT(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [24];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One transaction on the WAIT=2 instance; lat counts edges from the
    // presentation cycle until rsp_valid is seen.
    task automatic txn2(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        bus2.req_valid  = 1'b1;
        bus2.req_we     = we;
        bus2.req_addr   = addr;
        bus2.req_funct3 = f3;
        bus2.req_wdata  = wdata;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = bus2.rsp_rdata;
        err   = bus2.rsp_err;
        bus2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus2.rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] hold_rdata;
    logic        hold_err;

    logic        w0_we    [5];
    logic [31:0] w0_addr  [5];
    logic [31:0] w0_wdata [5];
    logic [31:0] w0_exp   [5];

    initial begin
        //           we    addr        f3      wdata         exp_rdata     err
        vecs[0]  = '{1'b1, 32'h00,   3'b010, 32'h55AA55AA, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 32'h10,   3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h13,   3'b000, 32'h12345680, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,   3'b000, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[5]  = '{1'b0, 32'h13,   3'b100, 32'h0,        32'h00000080, 1'b0};
        vecs[6]  = '{1'b0, 32'h10,   3'b010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[7]  = '{1'b0, 32'h12,   3'b001, 32'h0,        32'hFFFF80AD, 1'b0};
        vecs[8]  = '{1'b0, 32'h12,   3'b101, 32'h0,        32'h000080AD, 1'b0};
        vecs[9]  = '{1'b1, 32'h11,   3'b001, 32'h0000CAFE, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 32'h10,   3'b010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[11] = '{1'b0, 32'h02,   3'b010, 32'h0,        32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 32'h10,   3'b011, 32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 32'h1000, 3'b010, 32'h11111111, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 32'h00,   3'b010, 32'h0,        32'h55AA55AA, 1'b0};
        vecs[15] = '{1'b1, 32'h10,   3'b100, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[16] = '{1'b1, 32'h12,   3'b001, 32'hABCD1234, 32'h00000000, 1'b0};
        vecs[17] = '{1'b0, 32'h10,   3'b010, 32'h0,        32'h1234BEEF, 1'b0};
        vecs[18] = '{1'b1, 32'h10,   3'b000, 32'h0000007F, 32'h00000000, 1'b0};
        vecs[19] = '{1'b0, 32'h10,   3'b000, 32'h0,        32'h0000007F, 1'b0};
        vecs[20] = '{1'b0, 32'h11,   3'b000, 32'h0,        32'hFFFFFFBE, 1'b0};
        vecs[21] = '{1'b0, 32'h10,   3'b101, 32'h0,        32'h0000BE7F, 1'b0};
        vecs[22] = '{1'b1, 32'h20,   3'b010, 32'hA5A5A5A5, 32'h00000000, 1'b0};
        vecs[23] = '{1'b0, 32'h11,   3'b001, 32'h0,        32'h00000000, 1'b1};

        w0_we[0] = 1'b1; w0_addr[0] = 32'h40; w0_wdata[0] = 32'h01020304; w0_exp[0] = 32'h0;
        w0_we[1] = 1'b1; w0_addr[1] = 32'h44; w0_wdata[1] = 32'h0A0B0C0D; w0_exp[1] = 32'h0;
        w0_we[2] = 1'b0; w0_addr[2] = 32'h40; w0_wdata[2] = 32'h0;        w0_exp[2] = 32'h01020304;
        w0_we[3] = 1'b0; w0_addr[3] = 32'h44; w0_wdata[3] = 32'h0;        w0_exp[3] = 32'h0A0B0C0D;
        w0_we[4] = 1'b0; w0_addr[4] = 32'h40; w0_wdata[4] = 32'h0;        w0_exp[4] = 32'h01020304;

        rst = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'h0;
        bus2.req_funct3 = 3'b010; bus2.req_wdata = 32'h0; bus2.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'h0;
        bus0.req_funct3 = 3'b010; bus0.req_wdata = 32'h0; bus0.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("reset_req_ready", 32'(bus2.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus2.rsp_rdata, 32'h0);
        chk("reset_rsp_err",   32'(bus2.rsp_err), 32'd0);

        // Vector table on the WAIT=2 instance
        for (int i = 0; i < 24; i++) begin
            txn2(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, rd, er, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Backpressure: response held 5 cycles, stray request ignored
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0;
        bus2.req_addr = 32'h10; bus2.req_funct3 = 3'b010;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd3);
        hold_rdata = bus2.rsp_rdata;
        hold_err   = bus2.rsp_err;
        chk("bp_rdata", hold_rdata, 32'h1234BE7F);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus2.req_valid = 1'b1; bus2.req_we = 1'b1;
                bus2.req_addr = 32'h10; bus2.req_wdata = 32'hFFFFFFFF;
            end
            @(posedge clk); #1;
            bus2.req_valid = 1'b0; bus2.req_we = 1'b0;
            chk($sformatf("bp%0d_rsp_valid", c), 32'(bus2.rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rdata", c), bus2.rsp_rdata, hold_rdata);
            chk($sformatf("bp%0d_err", c), 32'(bus2.rsp_err), 32'(hold_err));
            chk($sformatf("bp%0d_req_ready", c), 32'(bus2.req_ready), 32'd0);
        end
        bus2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus2.rsp_ready = 1'b0;
        chk("bp_after_req_ready", 32'(bus2.req_ready), 32'd1);
        chk("bp_after_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp_after2_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        txn2(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        chk("bp_stray_not_written", rd, 32'h1234BE7F);

        // Reset on the would-be commit edge of a pending store
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h20;
        bus2.req_funct3 = 3'b010; bus2.req_wdata = 32'h12345678;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus2.req_ready), 32'd1);
        chk("rst_rsp_rdata", bus2.rsp_rdata, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_idle_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        end
        txn2(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        chk("rst_store_dropped", rd, 32'hA5A5A5A5);
        chk("rst_store_dropped_err", 32'(er), 32'd0);

        // WAIT=0 instance: continuous requests, rsp_ready tied high
        bus0.req_valid = 1'b1;
        bus0.req_we = w0_we[0]; bus0.req_addr = w0_addr[0];
        bus0.req_wdata = w0_wdata[0]; bus0.req_funct3 = 3'b010;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("w0_%0d_req_ready", k), 32'(bus0.req_ready), 32'd1);
            chk($sformatf("w0_%0d_idle_valid", k), 32'(bus0.rsp_valid), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("w0_%0d_rsp_valid", k), 32'(bus0.rsp_valid), 32'd1);
            chk($sformatf("w0_%0d_busy", k), 32'(bus0.req_ready), 32'd0);
            chk($sformatf("w0_%0d_rdata", k), bus0.rsp_rdata, w0_exp[k]);
            chk($sformatf("w0_%0d_err", k), 32'(bus0.rsp_err), 32'd0);
            if (k < 4) begin
                bus0.req_we = w0_we[k+1]; bus0.req_addr = w0_addr[k+1];
                bus0.req_wdata = w0_wdata[k+1];
            end
            @(posedge clk); #1;
        end
        bus0.req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
